pixel_frame_buffer: RTL and testbench
=====================================

PIXEL_FRAME_BUFFER -- requirements
Module: pixel_frame_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning bits per channel sample.
REQ-002 The block SHALL have parameter IMG_W, default 2, meaning image width in pixels.
REQ-003 The block SHALL have parameter IMG_H, default 2, meaning image height in pixels.
REQ-004 The block SHALL have parameter CHANNELS, default 3, meaning samples per pixel; DEPTH = IMG_W*IMG_H*CHANNELS.
REQ-005 Clock and reset SHALL be: clk  in  1  single clock, rising edge; rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle command strobe, sampled only in IDLE.
REQ-007 cmd  in  2  00 none, 01 write, 10 read, 11 clear; sampled with start.
REQ-008 abort  in  1  terminates any operation.
REQ-009 in_valid  in  1 / in_data  in  DATA_W / in_ready  out  1  write-stream handshake.
REQ-010 out_valid  out  1 / out_data  out  DATA_W / out_ready  in  1  read-stream handshake; out_ready low is backpressure.
REQ-011 out_chan  out  clog2(CHANNELS)  channel index of out_data; out_last  out  1  final word of frame.
REQ-012 busy  out  1  high in any non-IDLE state; done  out  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have states IDLE, WRITE, READ, CLEAR; start with cmd 01/10/11 in IDLE moves to WRITE/READ/CLEAR next cycle with address pointer 0; cmd 00 is ignored.
REQ-014 start SHALL be ignored while busy.
REQ-015 In WRITE, in_ready SHALL be 1; each cycle with in_valid&in_ready SHALL store in_data at the pointer and increment it; in_valid low stalls without advancing.
REQ-016 After the write accepted at pointer DEPTH-1, the FSM SHALL return to IDLE and pulse done on the following cycle.
REQ-017 In READ, out_valid SHALL first assert 2 cycles after the start strobe (1-cycle synchronous memory latency).
REQ-018 While out_valid & !out_ready, out_data, out_chan, out_last SHALL hold stable and the pointer SHALL not advance.
REQ-019 A word SHALL be consumed only on out_valid&out_ready; with out_ready held high, one word per cycle SHALL be produced with no bubbles.
REQ-020 out_chan SHALL count 0..CHANNELS-1 and wrap per pixel; out_last SHALL be 1 only with word DEPTH-1.
REQ-021 After the handshake of word DEPTH-1, out_valid SHALL drop, FSM SHALL enter IDLE, and done SHALL pulse the next cycle.
REQ-022 In CLEAR, one location per cycle SHALL be written to 0; DEPTH cycles, then IDLE with done pulse.
REQ-023 abort in any non-IDLE state SHALL force IDLE next cycle, deassert in_ready/out_valid, and SHALL NOT pulse done; abort wins over a simultaneous final handshake.
REQ-024 Outside READ with out_valid low, out_data SHALL be driven 0 (no tri-state).
REQ-025 Pointer width SHALL be clog2(DEPTH); comparisons SHALL use DEPTH-1 exactly, no wrap beyond.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, pointer 0, channel counter 0, and in_ready, out_valid, out_last, busy, done, out_data, out_chan all 0.
REQ-027 Memory contents SHALL NOT be reset; CLEAR is the only initialisation.
REQ-028 Reset asserted mid-operation SHALL abandon the operation without done.

Structure
REQ-029 Command encoding and state enumeration SHALL live in shared package pfb_pkg.
REQ-030 Storage SHALL be one sub-module pfb_mem: single-port synchronous RAM, DEPTH x DATA_W, 1-cycle read latency.

Verification
REQ-031 Defaults (DEPTH=12): write 0x10..0x1B with in_valid continuous -> in_ready high 12 cycles, done pulse 1 cycle after last accept, busy low.
REQ-032 Read after REQ-031 with out_ready=1 -> 0x10..0x1B on consecutive cycles, out_chan 0,1,2 repeating, out_last on 0x1B, done once.
REQ-033 Read with out_ready low for 3 cycles at word 5 -> out_data holds 0x15 for 3 cycles, sequence unbroken after release.
REQ-034 Clear then read -> 12 words of 0x00, done after each operation.
REQ-035 Abort at write word 6, then start issued while busy -> IDLE next cycle, no done, busy-time start ignored.
REQ-036 rst_n asserted mid-read -> all outputs 0 asynchronously; subsequent read returns pre-reset memory contents.

Source files
------------

// File: rtl/pfb_pkg.sv
// Shared types for the pixel frame buffer.
// Command encoding, controller states and an index-width helper.
package pfb_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WRITE = 2'b01,
    S_READ  = 2'b10,
    S_CLEAR = 2'b11
  } state_e;

  // Never returns 0 so a single-entry range still gets a 1-bit index
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_frame_buffer_if.sv
// Command, write-stream and read-stream bundle of the frame buffer.
// master drives commands and streams in; slave is the buffer.
interface pixel_frame_buffer_if
  import pfb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CHAN_W = 2
);

  logic              start;
  cmd_e              cmd;
  logic              abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CHAN_W-1:0] out_chan;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    output start, cmd, abort,
    output in_valid, in_data,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data,
    input  out_chan, out_last,
    input  busy, done
  );

  modport slave (
    input  start, cmd, abort,
    input  in_valid, in_data,
    input  out_ready,
    output in_ready,
    output out_valid, out_data,
    output out_chan, out_last,
    output busy, done
  );

endinterface

// File: rtl/pfb_mem.sv
// Single-port synchronous RAM, read-before-write, 1-cycle latency.
// Contents are deliberately not reset.
module pfb_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 12,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/pixel_frame_buffer.sv
// Frame buffer controller: streamed write, streamed read, clear.
// Reads re-address the RAM every cycle so stalled data stays stable.
module pixel_frame_buffer
  import pfb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int IMG_W    = 2,
  parameter int IMG_H    = 2,
  parameter int CHANNELS = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  pixel_frame_buffer_if.slave bus
);

  localparam int DEPTH  = IMG_W * IMG_H * CHANNELS;
  localparam int PTR_W  = idx_w(DEPTH);
  localparam int CHAN_W = idx_w(CHANNELS);

  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHANNELS - 1);

  state_e              r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [CHAN_W-1:0]   r_chan;
  logic                r_out_valid;
  logic                r_done;

  state_e              w_state_nxt;
  logic [PTR_W-1:0]    w_ptr_nxt;
  logic [CHAN_W-1:0]   w_chan_nxt;
  logic                w_ovld_nxt;
  logic                w_done_nxt;

  logic                w_we;
  logic [PTR_W-1:0]    w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_last;
  logic                w_wr_hs;
  logic                w_rd_hs;

  pfb_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign w_last  = (r_ptr == LAST_PTR);
  assign w_wr_hs = (r_state == S_WRITE) && bus.in_valid
                   && !bus.abort;
  assign w_rd_hs = (r_state == S_READ) && r_out_valid
                   && bus.out_ready && !bus.abort;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_chan_nxt  = r_chan;
    w_ovld_nxt  = r_out_valid;
    w_done_nxt  = 1'b0;
    w_we        = 1'b0;
    w_addr      = r_ptr;
    w_wdata     = '0;
    unique case (r_state)
      S_IDLE: begin
        w_ptr_nxt  = '0;
        w_chan_nxt = '0;
        w_ovld_nxt = 1'b0;
        if (bus.start) begin
          unique case (bus.cmd)
            CMD_WRITE: w_state_nxt = S_WRITE;
            CMD_READ:  w_state_nxt = S_READ;
            CMD_CLEAR: w_state_nxt = S_CLEAR;
            CMD_NONE:  w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_WRITE: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = '0;
        end else if (w_wr_hs) begin
          w_we    = 1'b1;
          w_wdata = bus.in_data;
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_ptr_nxt = r_ptr + 1'b1;
          end
        end
      end
      S_READ: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = '0;
          w_chan_nxt  = '0;
          w_ovld_nxt  = 1'b0;
        end else begin
          // First READ cycle fetches word 0; it is valid next cycle
          w_ovld_nxt = 1'b1;
          if (w_rd_hs) begin
            if (w_last) begin
              w_state_nxt = S_IDLE;
              w_ptr_nxt   = '0;
              w_chan_nxt  = '0;
              w_ovld_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_ptr_nxt  = r_ptr + 1'b1;
              w_addr     = r_ptr + 1'b1;
              w_chan_nxt = (r_chan == LAST_CHAN) ? '0
                           : r_chan + 1'b1;
            end
          end
        end
      end
      S_CLEAR: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_we = 1'b1;
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_ptr_nxt = r_ptr + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_chan      <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_chan      <= w_chan_nxt;
      r_out_valid <= w_ovld_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign bus.in_ready  = (r_state == S_WRITE) && !bus.abort;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_valid ? w_rdata : '0;
  assign bus.out_chan  = r_out_valid ? r_chan : '0;
  assign bus.out_last  = r_out_valid && w_last;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Self-checking bench for pixel_frame_buffer (12-word default frame).
// Reference: a plain array holding what the frame should contain.
module tb_pixel_frame_buffer;
  import pfb_pkg::*;

  localparam int DEPTH = 12;
  localparam int CH    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pixel_frame_buffer_if #(.DATA_W(8), .CHAN_W(2)) bus ();

  pixel_frame_buffer #(
    .DATA_W   (8),
    .IMG_W    (2),
    .IMG_H    (2),
    .CHANNELS (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] model [DEPTH];
  logic [7:0] wbuf  [DEPTH];

  typedef struct {
    bit   start;
    cmd_e cmd;
    bit   exp_busy;
    bit   exp_ready;
  } vec_t;

  vec_t vt [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: cycle budget expired at %0t", nm, $time);
  endtask

  task automatic idle_drive();
    bus.start     = 1'b0;
    bus.cmd       = CMD_NONE;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_in_ready"},  32'(bus.in_ready), 0);
    chk({nm, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({nm, "_out_data"},  32'(bus.out_data), 0);
    chk({nm, "_out_chan"},  32'(bus.out_chan), 0);
    chk({nm, "_out_last"},  32'(bus.out_last), 0);
    chk({nm, "_busy"},      32'(bus.busy), 0);
    chk({nm, "_done"},      32'(bus.done), 0);
  endtask

  task automatic do_write(input bit gaps);
    int idx;
    int cyc;
    bus.start = 1'b1;
    bus.cmd   = CMD_WRITE;
    step();
    bus.start = 1'b0;
    bus.cmd   = CMD_NONE;
    idx = 0;
    cyc = 0;
    while (idx < DEPTH && cyc < 200) begin
      bit v;
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_valid = v;
      bus.in_data  = wbuf[idx];
      #1;
      chk("wr_in_ready", 32'(bus.in_ready), 1);
      chk("wr_busy", 32'(bus.busy), 1);
      chk("wr_done_early", 32'(bus.done), 0);
      if (v) begin
        model[idx] = wbuf[idx];
        idx++;
      end
      cyc++;
      step();
    end
    bus.in_valid = 1'b0;
    if (idx < DEPTH) timeout("wr_timeout");
    #1;
    chk("wr_done", 32'(bus.done), 1);
    chk("wr_busy_end", 32'(bus.busy), 0);
    chk("wr_ready_end", 32'(bus.in_ready), 0);
    step();
    chk("wr_done_once", 32'(bus.done), 0);
  endtask

  // mode 0: out_ready high; mode 1: random backpressure
  task automatic do_read(input int mode, input int stall_at,
                         input int stall_len);
    int idx;
    int cyc;
    int stalled;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    bus.cmd       = CMD_READ;
    step();
    bus.start = 1'b0;
    bus.cmd   = CMD_NONE;
    #1;
    chk("rd_valid_lat", 32'(bus.out_valid), 0);
    chk("rd_busy", 32'(bus.busy), 1);
    step();
    idx = 0;
    cyc = 0;
    stalled = 0;
    while (idx < DEPTH && cyc < 200) begin
      bit r;
      r = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (idx == stall_at && stalled < stall_len) begin
        r = 1'b0;
        stalled++;
      end
      bus.out_ready = r;
      #1;
      chk("rd_valid", 32'(bus.out_valid), 1);
      chk($sformatf("rd_data%0d", idx), 32'(bus.out_data),
          32'(model[idx]));
      chk("rd_chan", 32'(bus.out_chan), 32'(idx % CH));
      chk("rd_last", 32'(bus.out_last), 32'(idx == DEPTH - 1));
      chk("rd_done_early", 32'(bus.done), 0);
      if (r) idx++;
      cyc++;
      step();
    end
    if (idx < DEPTH) timeout("rd_timeout");
    #1;
    chk("rd_valid_end", 32'(bus.out_valid), 0);
    chk("rd_data_end", 32'(bus.out_data), 0);
    chk("rd_done", 32'(bus.done), 1);
    chk("rd_busy_end", 32'(bus.busy), 0);
    step();
    chk("rd_done_once", 32'(bus.done), 0);
    bus.out_ready = 1'b0;
  endtask

  task automatic do_clear();
    bus.start = 1'b1;
    bus.cmd   = CMD_CLEAR;
    step();
    bus.start = 1'b0;
    bus.cmd   = CMD_NONE;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      chk("clr_busy", 32'(bus.busy), 1);
      chk("clr_done_early", 32'(bus.done), 0);
      step();
    end
    #1;
    chk("clr_done", 32'(bus.done), 1);
    chk("clr_busy_end", 32'(bus.busy), 0);
    step();
    chk("clr_done_once", 32'(bus.done), 0);
    for (int k = 0; k < DEPTH; k++) model[k] = 8'h00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, CMD_WRITE, 1'b0, 1'b0};
    vt[1] = '{1'b1, CMD_NONE,  1'b0, 1'b0};
    vt[2] = '{1'b1, CMD_WRITE, 1'b1, 1'b1};
    vt[3] = '{1'b1, CMD_READ,  1'b1, 1'b0};
    vt[4] = '{1'b1, CMD_CLEAR, 1'b1, 1'b0};
    vt[5] = '{1'b0, CMD_CLEAR, 1'b0, 1'b0};

    idle_drive();
    rst_n = 1'b0;
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Command response from IDLE, aborted after one cycle
    for (int i = 0; i < 6; i++) begin
      bus.start = vt[i].start;
      bus.cmd   = vt[i].cmd;
      step();
      bus.start = 1'b0;
      bus.cmd   = CMD_NONE;
      #1;
      chk($sformatf("tbl%0d_busy", i), 32'(bus.busy),
          32'(vt[i].exp_busy));
      chk($sformatf("tbl%0d_ready", i), 32'(bus.in_ready),
          32'(vt[i].exp_ready));
      chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 0);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      #1;
      chk($sformatf("tbl%0d_idle", i), 32'(bus.busy), 0);
      chk($sformatf("tbl%0d_nodone", i), 32'(bus.done), 0);
    end

    do_clear();
    do_read(0, -1, 0);

    for (int k = 0; k < DEPTH; k++) wbuf[k] = 8'(8'h10 + k);
    do_write(1'b0);
    do_read(0, -1, 0);
    do_read(0, 5, 3);

    // Abort at word 6, with a start issued mid-write
    for (int k = 0; k < DEPTH; k++) wbuf[k] = 8'(8'hA0 + k);
    bus.start = 1'b1;
    bus.cmd   = CMD_WRITE;
    step();
    bus.start = 1'b0;
    bus.cmd   = CMD_NONE;
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = wbuf[k];
      if (k == 3) begin
        bus.start = 1'b1;
        bus.cmd   = CMD_READ;
      end
      #1;
      chk($sformatf("ab_ready%0d", k), 32'(bus.in_ready), 1);
      chk("ab_no_valid", 32'(bus.out_valid), 0);
      model[k] = wbuf[k];
      step();
      bus.start = 1'b0;
      bus.cmd   = CMD_NONE;
    end
    bus.in_data = wbuf[6];
    bus.abort   = 1'b1;
    #1;
    chk("ab_ready_gated", 32'(bus.in_ready), 0);
    step();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("ab_idle", 32'(bus.busy), 0);
    chk("ab_nodone", 32'(bus.done), 0);
    chk("ab_ready_low", 32'(bus.in_ready), 0);
    step();
    chk("ab_nodone2", 32'(bus.done), 0);
    do_read(0, -1, 0);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < DEPTH; k++) wbuf[k] = 8'($urandom);
      do_write(1'b1);
      do_read(1, -1, 0);
    end

    // Reset in the middle of a read
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    bus.cmd       = CMD_READ;
    step();
    bus.start = 1'b0;
    bus.cmd   = CMD_NONE;
    repeat (5) step();
    #1;
    chk("mr_valid_before", 32'(bus.out_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    bus.out_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("mr_nodone", 32'(bus.done), 0);
    chk("mr_idle", 32'(bus.busy), 0);
    do_read(0, -1, 0);

    do_clear();
    do_read(1, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
